q_alu_seq: RTL and testbench

Sequential, parametrised Q-format arithmetic unit: add, sub, mul, div on signed Q(FIXED_BITS).(FRACTIONAL_BITS) operands, behind a valid/ready handshake. It adds optional saturation, optional multiply rounding, overflow/divide-by-zero flags and an iterative restoring divider, which removes the wide combinational divide. It sits between fixed-point datapath stages (filters, activation/MAC blocks) that need flow control and a bounded critical path.

---
 rtl/q_format_pkg.sv | 30 +++
 rtl/q_alu_seq_div.sv | 59 +++++
 rtl/q_alu_seq.sv | 155 +++++++++++++++
 tb/tb_q_alu_seq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/q_format_pkg.sv
// rtl/q_format_pkg.sv - shared encodings and default widths for the Q-format arithmetic unit
package q_format_pkg;

    localparam int Q_FIXED_BITS_DEF = 8;
    localparam int Q_FRAC_BITS_DEF  = 8;

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_SUB = 2'b01,
        OP_MUL = 2'b10,
        OP_DIV = 2'b11
    } q_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DIV  = 2'b01,
        ST_DONE = 2'b10
    } q_state_e;

    // Largest positive Q value, zero-extended to xw bits
    function automatic logic [127:0] q_max_ext(input int w);
        return (128'd1 << (w - 1)) - 128'd1;
    endfunction

    // Most negative Q value as a magnitude, zero-extended to xw bits
    function automatic logic [127:0] q_min_mag(input int w);
        return 128'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/q_alu_seq_div.sv
// rtl/q_alu_seq_div.sv - iterative restoring divider, one quotient bit per cycle
module q_div_seq #(
    parameter int N  = 24,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [N-1:0]  dividend,
    input  logic [DW-1:0] divisor,
    output logic [N-1:0]  quotient,
    output logic          done
);

    localparam int CW = $clog2(N + 1);

    logic [N-1:0]  dvd_q, quo_q, quo_d;
    logic [DW-1:0] dvs_q, rem_q, rem_d;
    logic [CW-1:0] cnt_q;
    logic [DW:0]   shifted;
    logic [DW+1:0] diff;
    logic          fits;

    // One restoring step: shift in the next dividend bit and subtract the divisor if it fits
    always_comb begin
        shifted = {rem_q, dvd_q[N-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        fits    = !diff[DW+1];
        rem_d   = fits ? diff[DW-1:0] : shifted[DW-1:0];
        quo_d   = {quo_q[N-2:0], fits};
    end

    // Load operands on start, then step until the down-counter reaches zero
    always_ff @(posedge clk) begin
        if (rst) begin
            dvd_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            dvd_q <= dividend;
            dvs_q <= divisor;
            rem_q <= '0;
            quo_q <= '0;
            cnt_q <= CW'(N);
        end else if (cnt_q != '0) begin
            dvd_q <= {dvd_q[N-2:0], 1'b0};
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // The final step's quotient is presented while that step is being taken
    assign quotient = quo_d;
    assign done     = (cnt_q == CW'(1));

endmodule

// File: rtl/q_alu_seq.sv
// rtl/q_alu_seq.sv - sequential Q-format add/sub/mul/div unit with valid/ready handshake
module q_alu_seq
    import q_format_pkg::*;
#(
    parameter int FIXED_BITS      = Q_FIXED_BITS_DEF,
    parameter int FRACTIONAL_BITS = Q_FRAC_BITS_DEF,
    parameter int SATURATE        = 1,
    parameter int ROUND           = 1
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [FIXED_BITS+FRACTIONAL_BITS-1:0] a,
    input  logic [FIXED_BITS+FRACTIONAL_BITS-1:0] b,
    input  logic [1:0]                            op,
    output logic                                  out_valid,
    input  logic                                  out_ready,
    output logic [FIXED_BITS+FRACTIONAL_BITS-1:0] result,
    output logic                                  ovf,
    output logic                                  div0
);

    localparam int W  = FIXED_BITS + FRACTIONAL_BITS;
    localparam int F  = FRACTIONAL_BITS;
    localparam int N  = W + F;
    localparam int XW = 2 * W + F + 2;

    localparam logic [127:0]           MAX_EXT = q_max_ext(W);
    localparam logic [127:0]           MIN_MAG = q_min_mag(W);
    localparam logic signed [XW-1:0]   Q_MAX   = MAX_EXT[XW-1:0];
    localparam logic signed [XW-1:0]   Q_MIN   = -$signed(MIN_MAG[XW-1:0]);
    localparam logic signed [XW-1:0]   HALF    = (F > 0) ? (XW'(1) << (F - 1)) : '0;

    // Returns {overflow, W-bit result} after clamping or wrapping an exact value
    function automatic logic [W:0] fit(input logic signed [XW-1:0] v);
        logic         o;
        logic [W-1:0] r;
        o = (v > Q_MAX) || (v < Q_MIN);
        if (SATURATE != 0 && v > Q_MAX)      r = Q_MAX[W-1:0];
        else if (SATURATE != 0 && v < Q_MIN) r = Q_MIN[W-1:0];
        else                                 r = v[W-1:0];
        return {o, r};
    endfunction

    q_state_e             state_q, state_d;
    logic [W-1:0]         result_q, result_d;
    logic                 ovf_q, ovf_d, div0_q, div0_d, out_valid_q, out_valid_d;
    logic                 neg_q, neg_d;
    logic                 accept, div_start, div_done;
    logic [N-1:0]         div_quo;
    logic [W-1:0]         a_mag, b_mag;
    logic signed [XW-1:0] sa, sb, prod, arith_v, div_v;
    logic [W:0]           arith_fit, div_fit;
    q_op_e                op_e;

    assign op_e     = q_op_e'(op);
    assign in_ready = !rst && (state_q == ST_IDLE || (state_q == ST_DONE && out_ready));
    assign accept   = in_valid && in_ready;
    assign a_mag    = a[W-1] ? (~a + W'(1)) : a;
    assign b_mag    = b[W-1] ? (~b + W'(1)) : b;

    q_div_seq #(.N(N), .DW(W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .dividend ({a_mag, {F{1'b0}}}),
        .divisor  (b_mag),
        .quotient (div_quo),
        .done     (div_done)
    );

    // Exact single-cycle results for add/sub/mul and the signed divider quotient
    always_comb begin
        sa   = {{(XW-W){a[W-1]}}, a};
        sb   = {{(XW-W){b[W-1]}}, b};
        prod = sa * sb;
        if (ROUND != 0) prod = prod + HALF;
        case (op_e)
            OP_ADD:  arith_v = sa + sb;
            OP_SUB:  arith_v = sa - sb;
            OP_MUL:  arith_v = prod >>> F;
            default: arith_v = '0;
        endcase
        div_v     = neg_q ? -$signed({{(XW-N){1'b0}}, div_quo})
                          : $signed({{(XW-N){1'b0}}, div_quo});
        arith_fit = fit(arith_v);
        div_fit   = fit(div_v);
    end

    // Handshake FSM: drain DONE, finish DIV, then let a new accept override
    always_comb begin
        state_d     = state_q;
        result_d    = result_q;
        ovf_d       = ovf_q;
        div0_d      = div0_q;
        out_valid_d = out_valid_q;
        neg_d       = neg_q;
        div_start   = 1'b0;
        if (state_q == ST_DONE && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
        end
        if (state_q == ST_DIV && div_done) begin
            {ovf_d, result_d} = div_fit;
            div0_d      = 1'b0;
            out_valid_d = 1'b1;
            state_d     = ST_DONE;
        end
        if (accept) begin
            if (op_e == OP_DIV && b == '0) begin
                result_d    = '0;
                ovf_d       = 1'b0;
                div0_d      = 1'b1;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end else if (op_e == OP_DIV) begin
                neg_d       = a[W-1] ^ b[W-1];
                div_start   = 1'b1;
                out_valid_d = 1'b0;
                state_d     = ST_DIV;
            end else begin
                {ovf_d, result_d} = arith_fit;
                div0_d      = 1'b0;
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
        end
    end

    // State and registered outputs; reset drops any pending result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            div0_q      <= 1'b0;
            out_valid_q <= 1'b0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            ovf_q       <= ovf_d;
            div0_q      <= div0_d;
            out_valid_q <= out_valid_d;
            neg_q       <= neg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign ovf       = ovf_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_q_alu_seq.sv
// tb/tb_q_alu_seq.sv - self-checking bench for q_alu_seq (Q8.8, saturating/rounding and wrapping/flooring builds)
module tb_q_alu_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] a = '0, b = '0;
    logic [1:0]  op = '0;
    logic        in_ready_s, out_valid_s, ovf_s, div0_s;
    logic        in_ready_w, out_valid_w, ovf_w, div0_w;
    logic [15:0] result_s, result_w;

    int checks = 0;
    int errors = 0;
    bit busy_ok;

    always #5 clk = ~clk;

    q_alu_seq dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
        .a(a), .b(b), .op(op), .out_valid(out_valid_s), .out_ready(out_ready),
        .result(result_s), .ovf(ovf_s), .div0(div0_s)
    );

    q_alu_seq #(.SATURATE(0), .ROUND(0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
        .a(a), .b(b), .op(op), .out_valid(out_valid_w), .out_ready(out_ready),
        .result(result_w), .ovf(ovf_w), .div0(div0_w)
    );

    typedef struct {
        logic [1:0]  op;
        logic [15:0] a, b, exp_s, exp_w;
        logic        ovf, d0;
        int          lat;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: real-valued Q8.8 arithmetic on plain integers
    function automatic void model(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb,
                                  input bit sat, input bit rnd,
                                  output logic [15:0] r, output bit ov, output bit d0);
        longint x, y, v;
        x = longint'($signed(va));
        y = longint'($signed(vb));
        d0 = 0;
        case (o)
            2'd0: v = x + y;
            2'd1: v = x - y;
            2'd2: begin
                v = x * y;
                if (rnd) v = v + 128;
                v = v >>> 8;
            end
            default: begin
                if (y == 0) begin
                    r = 16'h0; ov = 0; d0 = 1;
                    return;
                end
                v = (x * 256) / y;
            end
        endcase
        ov = (v > 32767) || (v < -32768);
        if (sat && v > 32767)       r = 16'h7FFF;
        else if (sat && v < -32768) r = 16'h8000;
        else                        r = v[15:0];
    endfunction

    // Issue one op with out_ready high; returns cycles from accept to out_valid
    task automatic run_op(input logic [1:0] o, input logic [15:0] va, input logic [15:0] vb, output int lat);
        int g;
        @(negedge clk);
        op = o; a = va; b = vb; in_valid = 1'b1;
        g = 0;
        while (!in_ready_s && g < 100) begin
            @(negedge clk);
            g++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid_s && lat < 100) begin
            if (in_ready_s) busy_ok = 0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        bit seen;
        logic [15:0] er_s, er_w;
        bit eo_s, eo_w, ed;
        logic [1:0] ro;
        logic [15:0] ra, rb;

        vecs[0] = '{2'd0, 16'h0180, 16'h0240, 16'h03C0, 16'h03C0, 1'b0, 1'b0, 1};
        vecs[1] = '{2'd1, 16'h0180, 16'h0240, 16'hFF40, 16'hFF40, 1'b0, 1'b0, 1};
        vecs[2] = '{2'd2, 16'h0180, 16'h0240, 16'h0360, 16'h0360, 1'b0, 1'b0, 1};
        vecs[3] = '{2'd2, 16'h0001, 16'h0080, 16'h0001, 16'h0000, 1'b0, 1'b0, 1};
        vecs[4] = '{2'd3, 16'h0300, 16'h0180, 16'h0200, 16'h0200, 1'b0, 1'b0, 25};
        vecs[5] = '{2'd3, 16'hFD00, 16'h0180, 16'hFE00, 16'hFE00, 1'b0, 1'b0, 25};
        vecs[6] = '{2'd0, 16'h7F00, 16'h0200, 16'h7FFF, 16'h8100, 1'b1, 1'b0, 1};
        vecs[7] = '{2'd3, 16'h7F00, 16'h0001, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 25};
        vecs[8] = '{2'd3, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
        vecs[9] = '{2'd3, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000, 1'b1, 1'b0, 25};

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outs", {out_valid_s, ovf_s, div0_s, result_s, out_valid_w, result_w},
            {1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0});
        chk("reset_in_ready", {in_ready_s, in_ready_w}, 2'b00);
        rst = 1'b0;

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            busy_ok = 1;
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            chk($sformatf("v%0d_res_sat", i), result_s, vecs[i].exp_s);
            chk($sformatf("v%0d_res_wrap", i), result_w, vecs[i].exp_w);
            chk($sformatf("v%0d_ovf", i), {ovf_s, ovf_w}, {vecs[i].ovf, vecs[i].ovf});
            chk($sformatf("v%0d_div0", i), {div0_s, div0_w}, {vecs[i].d0, vecs[i].d0});
            chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            if (vecs[i].lat > 1) chk($sformatf("v%0d_in_ready_low_in_div", i), busy_ok, 1);
        end

        // Back-to-back add then sub
        @(negedge clk);
        op = 2'd0; a = 16'h0180; b = 16'h0240; in_valid = 1'b1;
        @(posedge clk); #1;
        chk("b2b_add", {out_valid_s, result_s}, {1'b1, 16'h03C0});
        op = 2'd1;
        chk("b2b_ready", in_ready_s, 1'b1);
        @(posedge clk); #1;
        chk("b2b_sub", {out_valid_s, result_s}, {1'b1, 16'hFF40});
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain", out_valid_s, 1'b0);

        // Divide by zero held under backpressure; a second request is refused
        out_ready = 1'b0;
        run_op(2'd3, 16'h0100, 16'h0000, lat);
        chk("div0_latency", lat, 1);
        op = 2'd0; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk($sformatf("hold_%0d", k), {out_valid_s, in_ready_s, div0_s, ovf_s, result_s},
                {1'b1, 1'b0, 1'b1, 1'b0, 16'h0});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", out_valid_s, 1'b0);

        // Reset in the middle of a divide
        @(negedge clk);
        op = 2'd3; a = 16'h0300; b = 16'h0180; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_outs", {out_valid_s, result_s, ovf_s, div0_s, in_ready_s}, {1'b0, 16'h0, 1'b0, 1'b0, 1'b0});
        rst = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("abort_idle", in_ready_s, 1'b1);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (out_valid_s) seen = 1;
        end
        chk("abort_dropped", seen, 1'b0);
        out_ready = 1'b1;
        run_op(2'd0, 16'h0100, 16'h0100, lat);
        chk("post_abort_add", {result_s, ovf_s}, {16'h0200, 1'b0});
        chk("post_abort_latency", lat, 1);

        // Random operations against the reference model
        for (int n = 0; n < 150; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                ra = 16'($signed(ra) >>> 6);
                rb = (rb == 0) ? rb : 16'($signed(rb) >>> 5);
            end
            model(ro, ra, rb, 1, 1, er_s, eo_s, ed);
            model(ro, ra, rb, 0, 0, er_w, eo_w, ed);
            run_op(ro, ra, rb, lat);
            chk($sformatf("rnd%0d_op%0d_%h_%h_sat", n, ro, ra, rb), {result_s, ovf_s, div0_s}, {er_s, eo_s, ed});
            chk($sformatf("rnd%0d_op%0d_%h_%h_wrap", n, ro, ra, rb), {result_w, ovf_w, div0_w}, {er_w, eo_w, ed});
            chk($sformatf("rnd%0d_latency", n), lat, (ro == 2'd3 && rb != 0) ? 25 : 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
